fetch_queue: RTL and testbench

- Instruction prefetch stage that sits between instruction memory and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues them to instruction memory, which has a pipelined, in-order response path.
- Buffers returned instructions, each with its PC+4, in a small FIFO.
- Holds output while the hazard unit stalls decode; flushes on a taken-branch redirect from the MEM stage.

---
 rtl/fetchq_pkg.sv | 33 +++
 rtl/fetchq_fifo.sv | 78 +++++++
 rtl/fetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetchq_pkg.sv
// ============================================================================
// Module      : fetchq_pkg
// Description : Shared constants, entry type and width helper for the
//               instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetchq_pkg;

  localparam int          AW_DEF       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // One buffered fetch result: the instruction and the PC of the next word.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fq_entry_t;

  // Ceiling log2, used to size pointers (returns 0 for values <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetchq_fifo.sv
// ============================================================================
// Module      : fetchq_fifo
// Description : Generic synchronous FIFO with push, pop and clear. The head
//               entry is presented combinationally. DEPTH must be a power of
//               two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetchq_fifo
  import fetchq_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int c_PW  = clog2(DEPTH),
  localparam int c_CW  = c_PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [c_CW-1:0]  o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Clear wins over everything; push into a full FIFO or pop from an empty one is ignored.
  assign w_do_push = i_push && !i_clear && (r_count != c_CW'(DEPTH));
  assign w_do_pop  = i_pop  && !i_clear && (r_count != '0);

  assign o_head_data = r_mem[r_rptr];
  assign o_full      = (r_count == c_CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue. Issues sequential word fetches to
//               a pipelined in-order instruction memory, buffers the returned
//               instructions with their PC+4, holds the head while decode
//               stalls and flushes on a taken-branch redirect.
//               Optional macro FETCHQ_BYPASS_EN: an undropped response that
//               arrives while the queue is empty is presented on out_* in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = AW_DEF,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [AW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  output logic [AW-1:0] out_instr,
  output logic [AW-1:0] out_pc_plus4,
  input  logic          out_ready
);

  localparam int c_PW = clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_SW = c_CW + 1;
  localparam int c_EW = $bits(fq_entry_t);

  logic [AW-1:0]   r_fetch_pc;
  logic [c_CW-1:0] r_drop_cnt;
  logic [c_CW-1:0] w_occupancy;
  logic [c_CW-1:0] w_outstanding;
  logic [c_SW-1:0] w_credit_sum;
  logic [AW-1:0]   w_tag_head;
  logic [AW-1:0]   w_resp_pc4;
  fq_entry_t       w_push_entry;
  fq_entry_t       w_head_entry;
  logic            w_entry_full;
  logic            w_entry_empty;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic            w_issue;
  logic            w_resp;
  logic            w_resp_live;
  logic            w_push;
  logic            w_pop;

  // Every issued request holds a credit until its response returns, so the
  // entry FIFO can never overflow. The in-flight count is the tag FIFO count.
  assign w_credit_sum = {1'b0, w_occupancy} + {1'b0, w_outstanding};
  assign w_issue      = reset && !redirect_valid && !w_tag_full &&
                        (w_credit_sum < c_SW'(DEPTH));
  assign imem_req     = w_issue;
  assign imem_addr    = r_fetch_pc;

  // A response without a matching tag cannot occur in a consistent system; it is ignored.
  assign w_resp       = imem_rvalid && !w_tag_empty;
  assign w_resp_pc4   = w_tag_head + AW'(PC_STEP);
  assign w_resp_live  = w_resp && (r_drop_cnt == '0) && !redirect_valid;
  assign w_push_entry = '{instr: imem_rdata, pc_plus4: w_resp_pc4};
  assign w_pop        = !w_entry_empty && out_ready && !redirect_valid;

`ifdef FETCHQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass     = w_resp_live && w_entry_empty;
  assign w_push       = w_resp_live && !w_entry_full && !(w_bypass && out_ready);
  assign out_valid    = !w_entry_empty || w_bypass;
  assign out_instr    = w_bypass ? imem_rdata : w_head_entry.instr;
  assign out_pc_plus4 = w_bypass ? w_resp_pc4 : w_head_entry.pc_plus4;
`else
  assign w_push       = w_resp_live && !w_entry_full;
  assign out_valid    = !w_entry_empty;
  assign out_instr    = w_head_entry.instr;
  assign out_pc_plus4 = w_head_entry.pc_plus4;
`endif

  // Returned instructions with their PC+4; flushed by a redirect.
  fetchq_fifo #(
    .WIDTH (c_EW),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_clear     (redirect_valid),
    .o_head_data (w_head_entry),
    .o_full      (w_entry_full),
    .o_empty     (w_entry_empty),
    .o_count     (w_occupancy)
  );

  // Addresses of in-flight requests; popped by every response, stale or not.
  fetchq_fifo #(
    .WIDTH (AW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_issue),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_resp),
    .i_clear     (1'b0),
    .o_head_data (w_tag_head),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty),
    .o_count     (w_outstanding)
  );

  // Fetch address: a redirect wins, otherwise advance past each issued request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + AW'(PC_STEP);
    end
  end

  // Stale-response counter. Every request still in flight at a redirect
  // belongs to the abandoned path; an earlier redirect's stale requests are
  // already part of that in-flight set, so back-to-back redirects stay exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= w_outstanding - c_CW'(w_resp);
    end else if (w_resp && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (default build) with a
//               fixed-latency in-order memory model and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int c_DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        out_ready = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          issues = 0;
  int          first_valid_cyc = -1;
  logic [31:0] exp_pc = '0;
  bit          drive_redirect = 1'b0;
  logic [31:0] redir_target = '0;
  bit          ready_ctl = 1'b0;
  bit          last_out_valid = 1'b0;
  bit          last_issued = 1'b0;
  logic [31:0] last_iss_addr = '0;
  req_t        mem_q[$];
  logic [63:0] sb[$];
  logic [31:0] popped[$];

  fetch_queue #(
    .DEPTH    (c_DEPTH),
    .AW       (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hCAFE_0000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, update the model.
  task automatic step();
    bit   resp;
    req_t r;
    @(negedge clk);
    cyc++;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid    = resp;
    imem_rdata     = resp ? instr_of(mem_q[0].addr) : 32'h0;
    redirect_valid = drive_redirect;
    redirect_pc    = redir_target;
    out_ready      = ready_ctl;
    #1;
    check_val("imem_req", {31'b0, imem_req},
              {31'b0, ((sb.size() + mem_q.size()) < c_DEPTH) && !drive_redirect});
    check_val("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    if (out_valid && sb.size() != 0) begin
      check_val("out_instr", out_instr, sb[0][63:32]);
      check_val("out_pc_plus4", out_pc_plus4, sb[0][31:0]);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    last_out_valid = out_valid;
    if (out_valid && out_ready && !drive_redirect && sb.size() != 0) begin
      popped.push_back(out_pc_plus4);
      void'(sb.pop_front());
    end
    if (resp) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !drive_redirect)
        sb.push_back({instr_of(r.addr), r.addr + 32'd4});
    end
    last_issued = 1'b0;
    if (drive_redirect) begin
      sb.delete();
      epoch++;
      exp_pc = redir_target;
    end else if (imem_req) begin
      check_val("imem_addr", imem_addr, exp_pc);
      r.addr = imem_addr;
      r.due  = cyc + lat;
      r.epoch = epoch;
      mem_q.push_back(r);
      exp_pc = exp_pc + 32'd4;
      issues++;
      last_issued = 1'b1;
      last_iss_addr = imem_addr;
    end
    drive_redirect = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    drive_redirect = 1'b0;
    #1;
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_val("rst_out_instr", out_instr, 32'd0);
    check_val("rst_out_pc4", out_pc_plus4, 32'd0);
    sb.delete();
    mem_q.delete();
    popped.delete();
    exp_pc = 32'h0;
    epoch++;
    cyc = 0;
    issues = 0;
    first_valid_cyc = -1;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_popped(input int n, input string tag);
    int k;
    k = 0;
    while (popped.size() < n && k < 40) begin
      step();
      k++;
    end
    if (popped.size() < n) check_val(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int bad;

    // Sequential fetch, latency 1, consumer always ready.
    do_reset();
    lat = 1;
    ready_ctl = 1'b1;
    repeat (12) step();
    check_val("first_valid_cyc", first_valid_cyc, 32'd3);
    check_val("seq_pop_count", popped.size(), 32'd10);
    check_val("seq_pc4_0", popped[0], 32'h4);
    check_val("seq_pc4_1", popped[1], 32'h8);
    check_val("seq_pc4_2", popped[2], 32'hC);

    // Decode stall: credits run out at DEPTH requests, then drain in order.
    do_reset();
    lat = 1;
    ready_ctl = 1'b0;
    repeat (10) step();
    check_val("stall_issues", issues, 32'd4);
    check_val("stall_occ", sb.size(), 32'd4);
    ready_ctl = 1'b1;
    repeat (4) step();
    check_val("drain_count", popped.size(), 32'd4);
    check_val("drain_last_pc4", popped[3], 32'h10);

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat = 3;
    ready_ctl = 1'b1;
    k = 0;
    while (mem_q.size() < 2 && k < 20) begin step(); k++; end
    check_val("inflight_two", mem_q.size(), 32'd2);
    drive_redirect = 1'b1;
    redir_target = 32'h100;
    step();
    wait_popped(1, "timeout_redirect1");
    check_val("redir1_pc4", popped[0], 32'h104);

    // Redirect colliding with a response and a pop, two entries queued.
    do_reset();
    lat = 1;
    ready_ctl = 1'b0;
    k = 0;
    while (!(sb.size() == 2 && mem_q.size() > 0 && mem_q[0].due <= cyc + 1) && k < 20) begin
      step();
      k++;
    end
    check_val("collide_setup", sb.size(), 32'd2);
    ready_ctl = 1'b1;
    drive_redirect = 1'b1;
    redir_target = 32'h40;
    step();
    step();
    check_val("collide_flushed", {31'b0, last_out_valid}, 32'd0);
    check_val("collide_issue", {31'b0, last_issued}, 32'd1);
    check_val("collide_addr", last_iss_addr, 32'h40);
    wait_popped(1, "timeout_collide");
    check_val("collide_pc4", popped[0], 32'h44);

    // Back-to-back redirects at latency 2.
    do_reset();
    lat = 2;
    ready_ctl = 1'b1;
    repeat (6) step();
    popped.delete();
    drive_redirect = 1'b1;
    redir_target = 32'h200;
    step();
    drive_redirect = 1'b1;
    redir_target = 32'h300;
    step();
    repeat (15) step();
    check_val("b2b_count", (popped.size() > 0), 32'd1);
    check_val("b2b_first_pc4", popped[0], 32'h304);
    bad = 0;
    foreach (popped[i]) if (popped[i] >= 32'h200 && popped[i] <= 32'h2FF) bad++;
    check_val("b2b_no_0x200", bad, 32'd0);

    // Reset mid-stream with three entries queued.
    do_reset();
    lat = 1;
    ready_ctl = 1'b0;
    k = 0;
    while (sb.size() < 3 && k < 20) begin step(); k++; end
    check_val("midrst_occ", sb.size(), 32'd3);
    do_reset();
    ready_ctl = 1'b1;
    repeat (5) step();
    check_val("midrst_restart_pc4", popped[0], 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
